// File: rtl/parking_pkg.sv
// Shared types and BCD helpers for the parking occupancy controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENT_A,
        ENT_AB,
        ENT_B,
        EXT_B,
        EXT_AB,
        EXT_A
    } occ_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_count_t;

    // Callers guarantee the count is below 99, so tens never overflows.
    function automatic bcd_count_t bcd_inc(input bcd_count_t c);
        bcd_count_t r;
        r = c;
        if (c.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = c.tens + 4'd1;
        end else begin
            r.ones = c.ones + 4'd1;
        end
        return r;
    endfunction

    // Callers guarantee the count is nonzero, so tens never underflows.
    function automatic bcd_count_t bcd_dec(input bcd_count_t c);
        bcd_count_t r;
        r = c;
        if (c.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = c.tens - 4'd1;
        end else begin
            r.ones = c.ones - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer for one beam sensor, followed by a stable-count filter
// when DEBOUNCE_EN is defined (otherwise the synchronized level passes through).
module sensor_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] stable_cnt;

    // Counts consecutive cycles the input disagrees with the filtered level.
    always_ff @(posedge clk) begin
        if (rst) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_q[1] == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            level      <= sync_q[1];
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end
`else
    assign level = sync_q[1];
`endif

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Beam-sensor entry/exit sequencer with a clamped two-digit BCD occupancy count.
// Optional sensor debouncing is built when DEBOUNCE_EN is defined.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY        = 20,
    parameter int unsigned TIMEOUT_CYCLES  = 200_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_a,
    input  logic       sensor_b,
    output logic [3:0] tens_digit,
    output logic [3:0] ones_digit,
    output logic       full,
    output logic       empty,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       reject_pulse,
    output logic       error_pulse
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam bcd_count_t CAP_COUNT = {4'(CAPACITY / 10), 4'(CAPACITY % 10)};

    logic a, b;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .rst(rst), .raw(sensor_a), .level(a)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .rst(rst), .raw(sensor_b), .level(b)
    );

    // state is the observable FSM state for debug and checkers.
    occ_state_t      state, state_next;
    logic [TO_W-1:0] to_cnt;
    logic            entry_done, exit_done, timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE || state_next != state) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        entry_done = 1'b0;
        exit_done  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE:   if (a && !b) state_next = ENT_A;
                    else if (!a && b) state_next = EXT_B;
            ENT_A:  if (a && b) state_next = ENT_AB;
                    else if (!a && !b) state_next = IDLE;
            ENT_AB: if (!a && b) state_next = ENT_B;
                    else if (a && !b) state_next = ENT_A;
                    else if (!a && !b) state_next = IDLE;
            ENT_B:  if (!a && !b) begin
                        state_next = IDLE;
                        entry_done = 1'b1;
                    end else if (a && b) state_next = ENT_AB;
            EXT_B:  if (a && b) state_next = EXT_AB;
                    else if (!a && !b) state_next = IDLE;
            EXT_AB: if (a && !b) state_next = EXT_A;
                    else if (!a && b) state_next = EXT_B;
                    else if (!a && !b) state_next = IDLE;
            EXT_A:  if (!a && !b) begin
                        state_next = IDLE;
                        exit_done  = 1'b1;
                    end else if (a && b) state_next = EXT_AB;
            default: state_next = IDLE;
        endcase
        // A stalled sequence aborts regardless of what the sensors show now.
        if (state != IDLE && to_cnt == TO_LAST) begin
            state_next = IDLE;
            entry_done = 1'b0;
            exit_done  = 1'b0;
            timeout    = 1'b1;
        end
    end

    bcd_count_t count_q, count_d;
    logic       entry_d, exit_d, reject_d, error_d;

    always_comb begin
        count_d  = count_q;
        entry_d  = 1'b0;
        exit_d   = 1'b0;
        reject_d = 1'b0;
        error_d  = 1'b0;
        if (entry_done) begin
            if (count_q != CAP_COUNT) begin
                count_d = bcd_inc(count_q);
                entry_d = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end else if (exit_done) begin
            if (count_q != '0) begin
                count_d = bcd_dec(count_q);
                exit_d  = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end else if (timeout) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            entry_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
            error_pulse  <= 1'b0;
        end else begin
            count_q      <= count_d;
            full         <= (count_d == CAP_COUNT);
            empty        <= (count_d == '0);
            entry_pulse  <= entry_d;
            exit_pulse   <= exit_d;
            reject_pulse <= reject_d;
            error_pulse  <= error_d;
        end
    end

    assign tens_digit = count_q.tens;
    assign ones_digit = count_q.ones;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl (CAPACITY=20, TIMEOUT_CYCLES=50,
// DEBOUNCE_CYCLES=8; the glitch section is built only with DEBOUNCE_EN).
module tb_parking_occupancy_ctrl;
  import parking_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_a;
  logic       sensor_b;
  logic [3:0] tens_digit;
  logic [3:0] ones_digit;
  logic       full;
  logic       empty;
  logic       entry_pulse;
  logic       exit_pulse;
  logic       reject_pulse;
  logic       error_pulse;

  int tests  = 0;
  int failed = 0;
  int n_entry = 0;
  int n_exit = 0;
  int n_reject = 0;
  int n_error = 0;

  // clock / reset
  always #5 clk = ~clk;

  parking_occupancy_ctrl #(
    .CAPACITY(20),
    .TIMEOUT_CYCLES(50),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .tens_digit(tens_digit),
    .ones_digit(ones_digit),
    .full(full),
    .empty(empty),
    .entry_pulse(entry_pulse),
    .exit_pulse(exit_pulse),
    .reject_pulse(reject_pulse),
    .error_pulse(error_pulse)
  );

  // pulse monitor: each high cycle counts once, so a stretched pulse shows up
  always @(negedge clk) begin
    if (!rst) begin
      if (entry_pulse)  n_entry  <= n_entry + 1;
      if (exit_pulse)   n_exit   <= n_exit + 1;
      if (reject_pulse) n_reject <= n_reject + 1;
      if (error_pulse)  n_error  <= n_error + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic apply(input logic a, input logic b, input int cycles);
    sensor_a = a;
    sensor_b = b;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_entry();
    apply(1'b1, 1'b0, 4);
    apply(1'b1, 1'b1, 4);
    apply(1'b0, 1'b1, 4);
    apply(1'b0, 1'b0, 4);
  endtask

  task automatic do_exit();
    apply(1'b0, 1'b1, 4);
    apply(1'b1, 1'b1, 4);
    apply(1'b1, 1'b0, 4);
    apply(1'b0, 1'b0, 4);
  endtask

  initial begin
    rst = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    chk("reset_tens", 32'(tens_digit), 0);
    chk("reset_ones", 32'(ones_digit), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_pulses", 32'(n_entry + n_exit + n_reject + n_error), 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));

    // first entry
    do_entry();
    chk("entry1_pulses", 32'(n_entry), 1);
    chk("entry1_tens", 32'(tens_digit), 0);
    chk("entry1_ones", 32'(ones_digit), 1);
    chk("entry1_empty", 32'(empty), 0);

    // up to 09, then carry to 10
    for (int i = 0; i < 8; i++) do_entry();
    chk("cnt09_ones", 32'(ones_digit), 9);
    do_entry();
    chk("carry_tens", 32'(tens_digit), 1);
    chk("carry_ones", 32'(ones_digit), 0);

    // borrow back to 09
    do_exit();
    chk("borrow_exit_pulses", 32'(n_exit), 1);
    chk("borrow_tens", 32'(tens_digit), 0);
    chk("borrow_ones", 32'(ones_digit), 9);

    // fill to capacity
    for (int i = 0; i < 11; i++) do_entry();
    chk("cap_entries", 32'(n_entry), 21);
    chk("cap_tens", 32'(tens_digit), 2);
    chk("cap_ones", 32'(ones_digit), 0);
    chk("cap_full", 32'(full), 1);

    // entry while full is rejected
    do_entry();
    chk("reject_pulses", 32'(n_reject), 1);
    chk("reject_entries", 32'(n_entry), 21);
    chk("reject_tens", 32'(tens_digit), 2);
    chk("reject_ones", 32'(ones_digit), 0);
    chk("reject_full", 32'(full), 1);

    // drain to zero
    for (int i = 0; i < 20; i++) do_exit();
    chk("drain_exits", 32'(n_exit), 21);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_full", 32'(full), 0);

    // exit while empty
    do_exit();
    chk("empty_exit_error", 32'(n_error), 1);
    chk("empty_exit_pulses", 32'(n_exit), 21);
    chk("empty_exit_tens", 32'(tens_digit), 0);
    chk("empty_exit_ones", 32'(ones_digit), 0);
    chk("empty_exit_empty", 32'(empty), 1);

    // backed-out sequence
    apply(1'b1, 1'b0, 4);
    apply(1'b1, 1'b1, 4);
    chk("backout_mid_state", 32'(dut.state), 32'(ENT_AB));
    apply(1'b0, 1'b0, 4);
    chk("backout_state", 32'(dut.state), 32'(IDLE));
    chk("backout_no_pulse", 32'(n_entry + n_exit + n_reject + n_error), 21 + 21 + 1 + 1);

    // timeout: hold a; one abort happens near cycle 53, then release
    apply(1'b1, 1'b0, 30);
    chk("timeout_not_early_state", 32'(dut.state), 32'(ENT_A));
    chk("timeout_not_early_error", 32'(n_error), 1);
    apply(1'b1, 1'b0, 40);
    chk("timeout_error", 32'(n_error), 2);
    apply(1'b0, 1'b0, 6);
    chk("timeout_state", 32'(dut.state), 32'(IDLE));
    chk("timeout_error_once", 32'(n_error), 2);
    chk("timeout_tens", 32'(tens_digit), 0);
    chk("timeout_ones", 32'(ones_digit), 0);
    chk("timeout_entries", 32'(n_entry), 21);

`ifdef DEBOUNCE_EN
    // 5-cycle glitches never reach the FSM; a 20-cycle hold does
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 5);
      apply(1'b0, 1'b0, 12);
    end
    chk("glitch_state", 32'(dut.state), 32'(IDLE));
    apply(1'b1, 1'b0, 20);
    chk("hold_state", 32'(dut.state), 32'(ENT_A));
    apply(1'b0, 1'b0, 20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
